// File: rtl/dictionary_encoder.sv
// Dictionary encoder: replaces 32-bit lane values with IDs assigned in order of first
// appearance, then streams the dictionary out after the last beat of each stream.
module dictionary_encoder #(
  parameter int NUM_ELEMENTS = 16,
  parameter int DICT_SIZE    = 64,
  parameter int ID_WIDTH     = $clog2(DICT_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [32*NUM_ELEMENTS-1:0]       in_data_i,
  input  logic [NUM_ELEMENTS-1:0]          in_keep_i,
  input  logic                             in_last_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic [ID_WIDTH*NUM_ELEMENTS-1:0] out_ids_o,
  output logic [NUM_ELEMENTS-1:0]          out_keep_o,
  output logic                             out_last_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [31:0]                      dict_value_o,
  output logic                             dict_last_o,
  output logic                             dict_valid_o,
  input  logic                             dict_ready_i,
  output logic                             overflow_o
);

  localparam int LaneW  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int CountW = $clog2(DICT_SIZE + 1);

  typedef enum logic [1:0] {StIdle, StLookup, StEmit, StDump} state_e;

  state_e              state_q;
  logic [31:0]         beatData_q [NUM_ELEMENTS];
  logic [NUM_ELEMENTS-1:0] beatKeep_q;
  logic                beatLast_q;
  logic [LaneW-1:0]    lane_q;
  logic [CountW-1:0]   count_q;
  logic [31:0]         dict_q [DICT_SIZE];
  logic [ID_WIDTH-1:0] idLanes_q [NUM_ELEMENTS];
  logic [NUM_ELEMENTS-1:0] outKeep_q;
  logic [ID_WIDTH-1:0] dumpIdx_q;
  logic                firstBeat_q;
  logic                overflow_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                dict_valid_q;
  logic                dict_last_q;
  logic [31:0]         dict_value_q;

  logic [31:0]         laneValue;
  logic                laneKeep;
  logic                hit;
  logic [ID_WIDTH-1:0] hitIdx;

  // Descending scan so the lowest matching live entry wins.
  always_comb begin
    laneValue = beatData_q[lane_q];
    laneKeep  = beatKeep_q[lane_q];
    hit       = 1'b0;
    hitIdx    = '0;
    for (int i = DICT_SIZE - 1; i >= 0; i--) begin
      if ((CountW'(i) < count_q) && (dict_q[i] == laneValue)) begin
        hit    = 1'b1;
        hitIdx = ID_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      dict_valid_q <= 1'b0;
      dict_last_q  <= 1'b0;
      firstBeat_q  <= 1'b1;
      lane_q       <= '0;
      dumpIdx_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
              beatData_q[i] <= in_data_i[32*i +: 32];
            end
            beatKeep_q  <= in_keep_i;
            beatLast_q  <= in_last_i;
            lane_q      <= '0;
            in_ready_q  <= 1'b0;
            firstBeat_q <= 1'b0;
            if (firstBeat_q) overflow_q <= 1'b0;
            state_q     <= StLookup;
          end
        end
        StLookup: begin
          // A new entry written here is visible to the next lane's scan.
          if (!laneKeep) begin
            idLanes_q[lane_q] <= '0;
            outKeep_q[lane_q] <= 1'b0;
          end else if (hit) begin
            idLanes_q[lane_q] <= hitIdx;
            outKeep_q[lane_q] <= 1'b1;
          end else if (count_q < CountW'(DICT_SIZE)) begin
            idLanes_q[lane_q]          <= ID_WIDTH'(count_q);
            outKeep_q[lane_q]          <= 1'b1;
            dict_q[ID_WIDTH'(count_q)] <= laneValue;
            count_q                    <= count_q + CountW'(1);
          end else begin
            idLanes_q[lane_q] <= '0;
            outKeep_q[lane_q] <= 1'b0;
            overflow_q        <= 1'b1;
          end
          if (lane_q == LaneW'(NUM_ELEMENTS - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= StEmit;
          end else begin
            lane_q <= lane_q + LaneW'(1);
          end
        end
        StEmit: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (!beatLast_q) begin
              in_ready_q <= 1'b1;
              state_q    <= StIdle;
            end else if (count_q != '0) begin
              dumpIdx_q    <= '0;
              dict_value_q <= dict_q[0];
              dict_last_q  <= (count_q == CountW'(1));
              dict_valid_q <= 1'b1;
              state_q      <= StDump;
            end else begin
              count_q     <= '0;
              firstBeat_q <= 1'b1;
              in_ready_q  <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StDump: begin
          if (dict_ready_i) begin
            if (dict_last_q) begin
              dict_valid_q <= 1'b0;
              dict_last_q  <= 1'b0;
              count_q      <= '0;
              firstBeat_q  <= 1'b1;
              in_ready_q   <= 1'b1;
              state_q      <= StIdle;
            end else begin
              dumpIdx_q    <= dumpIdx_q + ID_WIDTH'(1);
              dict_value_q <= dict_q[dumpIdx_q + ID_WIDTH'(1)];
              dict_last_q  <= (CountW'(dumpIdx_q) + CountW'(2) == count_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : gIds
    assign out_ids_o[ID_WIDTH*g +: ID_WIDTH] = idLanes_q[g];
  end

  assign in_ready_o   = in_ready_q;
  assign out_keep_o   = outKeep_q;
  assign out_last_o   = beatLast_q;
  assign out_valid_o  = out_valid_q;
  assign dict_value_o = dict_value_q;
  assign dict_last_o  = dict_last_q;
  assign dict_valid_o = dict_valid_q;
  assign overflow_o   = overflow_q;

endmodule
